ysyx_24120013_core_ctrl: RTL and testbench
==========================================

# ysyx_24120013_core_ctrl

Multi-cycle sequencer for the ysyx_24120013 RV32 core. It drives the fetch handshake, holds the instruction register that feeds the decode stage, and gates the execute, memory and write-back phases. It also emits the register-file and PC write strobes, and stops the core on `ebreak` or on a bus timeout. It sits between the instruction/data memory interfaces and the IDU/EXU datapath.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles in any handshake state before the block enters the error state.
- `CNT_WIDTH`, default 8: width of the wait counter. Must satisfy `TIMEOUT` < 2^`CNT_WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifu_req_valid`  out  1  instruction fetch request.
- `ifu_req_ready`  in  1  instruction memory accepts the request.
- `ifu_rsp_valid`  in  1  instruction data valid.
- `ifu_rsp_data`  in  32  fetched instruction.
- `lsu_req_valid`  out  1  data memory request (load or store).
- `lsu_req_ready`  in  1  data memory accepts the request.
- `lsu_rsp_valid`  in  1  data memory access complete.
- `inst`  out  32  instruction register, fed to the IDU.
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `halted`  out  1  sticky; set by `ebreak`.
- `err`  out  1  sticky; set by timeout.
- `state`  out  4  current state, for debug.

## Operation
State encodings:
- IDLE=0, FETCH=1, WAIT_I=2, DECODE=3, EXEC=4, MEM=5, WAIT_D=6, WB=7, HALT=8, ERR=9.
- Encodings 10–15 are illegal. An illegal state moves to ERR on the next edge.

Transitions:
- IDLE: always moves to FETCH on the next edge.
- FETCH: `ifu_req_valid`=1. A handshake occurs when `ifu_req_valid` and `ifu_req_ready` are both high at an edge; FETCH then moves to WAIT_I.
- WAIT_I: `ifu_req_valid`=0. When `ifu_rsp_valid`=1 at an edge, `inst` captures `ifu_rsp_data` and the state moves to DECODE.
  - `ifu_rsp_valid` is ignored in every other state.
- DECODE: one cycle; the IDU reads the register file from `inst`. Moves to EXEC.
- EXEC: one cycle, then branches on `inst`:
  - opcode 0000011 (load) or 0100011 (store) → MEM;
  - `inst` == 32'h00100073 (`ebreak`) → HALT;
  - anything else → WB.
- MEM: `lsu_req_valid`=1 until the handshake, then moves to WAIT_D.
- WAIT_D: when `lsu_rsp_valid`=1, moves to WB.
- WB: a one-cycle pulse of `pc_we`=1. `rf_we`=1 except in these cases:
  - stores;
  - branches (opcode 1100011);
  - `inst[11:7]`==0.
  
  WB then moves to FETCH.
- HALT: terminal. `halted`=1 and all strobes are 0 until reset.
- ERR: terminal. `err`=1 and all strobes are 0 until reset.

Wait counter:
- Cleared on entry to FETCH, WAIT_I, MEM and WAIT_D.
- Increments each cycle the block remains in one of those states.
- If the counter equals `TIMEOUT` and the awaited handshake does not complete in that cycle, the next state is ERR.
- A handshake completing in the same cycle as the counter reaches `TIMEOUT` wins: no error.

Output decoding:
- All strobes are Moore outputs of the state, combinationally decoded.
- `inst` is registered.

## Timing
- Reset values:
  - state=IDLE; `inst`=32'h00000013 (nop); `halted`=0; `err`=0; counter=0.
  - All strobes (`ifu_req_valid`, `lsu_req_valid`, `rf_we`, `pc_we`) are 0.
- Asserting `rst` in any state, including mid-handshake, forces reset values immediately, without waiting for a clock edge.
  - An outstanding memory transaction is abandoned.
- Non-memory instruction with zero-wait memory (`ifu_req_ready` and `ifu_rsp_valid` already high): 5 cycles, FETCH→WAIT_I→DECODE→EXEC→WB.
- Load/store with zero-wait memory: 7 cycles.
- Each extra cycle of memory wait adds exactly one cycle.
- `pc_we` and `rf_we` are high for exactly one cycle per retired instruction.
- `ifu_req_valid` stays high every cycle in FETCH until accepted; it is never withdrawn early.
  - The same rule applies to `lsu_req_valid` in MEM.

## Test plan
- Reset, then hold `ifu_req_ready`=`ifu_rsp_valid`=1 with data 32'h00500093 (`addi x1,x0,5`):
  - `state` sequence 0,1,2,3,4,7,1;
  - `inst`=32'h00500093 from DECODE onward;
  - `rf_we`=`pc_we`=1 only in WB.
- Fetch 32'h0000a103 (`lw`) with `lsu_req_ready` delayed 3 cycles and `lsu_rsp_valid` 2 cycles after acceptance:
  - `lsu_req_valid` high for 4 cycles;
  - 11 cycles from FETCH to the return to FETCH;
  - `rf_we`=1 in WB.
- Store 32'h0020a023 and branch 32'h00208463:
  - WB has `pc_we`=1 and `rf_we`=0 in both cases;
  - the store passes through MEM and WAIT_D; the branch does not.
- Fetch 32'h00100073:
  - EXEC→HALT, `halted`=1;
  - no further `ifu_req_valid` for 20 cycles.
  - Then pulse `rst` mid-cycle: `halted`=0 and `state`=0 immediately, before the next edge.
- `ifu_req_ready` held 0:
  - ERR entered on the edge after the counter reaches 255, i.e. 256 cycles after FETCH entry;
  - `err`=1 sticky.
  - Repeat with `ready` rising in the cycle the counter equals 255: no error, the block proceeds to WAIT_I.

Source files
------------

// File: rtl/ysyx_24120013_core_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24120013_core_ctrl
//
// Multi-cycle sequencer for the ysyx_24120013 RV32 core. Steps each
// instruction through fetch, decode, execute, optional data-memory access
// and write-back. It holds the instruction register for the IDU, emits the
// PC and register-file write strobes, and stops the core on ebreak (HALT)
// or when a memory handshake stalls for too long (ERR).
//
// Parameters
//   TIMEOUT    maximum wait cycles in a handshake state before ERR
//   CNT_WIDTH  wait-counter width; TIMEOUT must fit (TIMEOUT < 2**CNT_WIDTH)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   ifu_req_valid    out  instruction fetch request (held until accepted)
//   ifu_req_ready    in   instruction memory accepts the request
//   ifu_rsp_valid    in   instruction data valid (sampled in WAIT_I only)
//   ifu_rsp_data     in   fetched instruction
//   lsu_req_valid    out  data memory request (held until accepted)
//   lsu_req_ready    in   data memory accepts the request
//   lsu_rsp_valid    in   data memory access complete (sampled in WAIT_D only)
//   inst             out  instruction register feeding the IDU
//   rf_we, pc_we     out  one-cycle write strobes in WB
//   halted, err      out  sticky terminal-state flags
//   state            out  current state encoding, for debug
// ---------------------------------------------------------------------------
module ysyx_24120013_core_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic [31:0] inst,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halted,
  output logic        err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_WAIT_I = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WAIT_D = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8,
    S_ERR    = 4'd9
  } state_e;

  localparam logic [31:0]          INST_NOP    = 32'h0000_0013;
  localparam logic [31:0]          INST_EBREAK = 32'h0010_0073;
  localparam logic [6:0]           OP_LOAD     = 7'b0000011;
  localparam logic [6:0]           OP_STORE    = 7'b0100011;
  localparam logic [6:0]           OP_BRANCH   = 7'b1100011;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT   = CNT_WIDTH'(TIMEOUT);

  state_e               state_q, state_d;
  logic [31:0]          inst_q, inst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       timed_out;
  logic       in_wait;
  logic [6:0] opcode;
  logic       is_store;
  logic       is_branch;

  assign opcode    = inst_q[6:0];
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign timed_out = (cnt_q == CNT_LIMIT);
  assign in_wait   = (state_q == S_FETCH)  || (state_q == S_WAIT_I) ||
                     (state_q == S_MEM)    || (state_q == S_WAIT_D);

  // Next-state and Moore output decode.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready)  state_d = S_WAIT_I;
        else if (timed_out) state_d = S_ERR;
      end

      S_WAIT_I: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end

      S_DECODE: state_d = S_EXEC;

      // ebreak's opcode (SYSTEM) never collides with load/store.
      S_EXEC: begin
        if (inst_q == INST_EBREAK)                     state_d = S_HALT;
        else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
        else                                           state_d = S_WB;
      end

      S_MEM: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready)  state_d = S_WAIT_D;
        else if (timed_out) state_d = S_ERR;
      end

      S_WAIT_D: begin
        if (lsu_rsp_valid)  state_d = S_WB;
        else if (timed_out) state_d = S_ERR;
      end

      // Stores and branches have no rd; writes to x0 are suppressed too.
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = !(is_store || is_branch || (inst_q[11:7] == 5'd0));
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_ERR: err = 1'b1;

      // Encodings 10-15 recover into the error state.
      default: state_d = S_ERR;
    endcase
  end

  // The wait counter restarts on every state change, so entering any
  // handshake state sees zero; it only counts while a handshake is pending.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && in_wait) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= INST_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst  = inst_q;
  assign state = state_q;

endmodule

// File: tb/tb_ysyx_24120013_core_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for ysyx_24120013_core_ctrl: a per-cycle vector table
// for straight-line instructions, plus hand-written sequences for memory
// wait states, ebreak with asynchronous reset, and the timeout boundary.
// ---------------------------------------------------------------------------
module tb_ysyx_24120013_core_ctrl;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [31:0] inst;
  logic        rf_we;
  logic        pc_we;
  logic        halted;
  logic        err;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_SW     = 32'h0020_a023;
  localparam logic [31:0] I_BEQ    = 32'h0020_8463;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_LW     = 32'h0000_a103;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  ysyx_24120013_core_ctrl #(.TIMEOUT(255), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .inst          (inst),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .halted        (halted),
    .err           (err),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  exp_state;
    logic [3:0]  exp_strb;   // {ifu_req_valid, lsu_req_valid, rf_we, pc_we}
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] d, input logic [3:0] s,
                     input logic [3:0] strb, input logic [31:0] i);
    vec_t v;
    v.data = d; v.exp_state = s; v.exp_strb = strb; v.exp_inst = i;
    vecs.push_back(v);
  endtask

  // Hold reset across one edge, release 1ns after it: the DUT is then in IDLE.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] strobes();
    return {ifu_req_valid, lsu_req_valid, rf_we, pc_we};
  endfunction

  initial begin
    int cycles, mem_n, wd_n, lv_n, rf_n, pc_n, strb_n;
    bit done;

    rst = 1'b1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'h0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    #1;
    check("reset.state",   32'(state), 32'd0);
    check("reset.inst",    inst, I_NOP);
    check("reset.strobes", 32'(strobes()), 32'd0);
    check("reset.flags",   32'({halted, err}), 32'd0);

    // addi, store, branch, nop back to back with zero-wait memories.
    //   data    state strobes  inst
    add(I_ADDI, 4'd0, 4'b0000, I_NOP);
    add(I_ADDI, 4'd1, 4'b1000, I_NOP);
    add(I_ADDI, 4'd2, 4'b0000, I_NOP);
    add(I_ADDI, 4'd3, 4'b0000, I_ADDI);
    add(I_ADDI, 4'd4, 4'b0000, I_ADDI);
    add(I_ADDI, 4'd7, 4'b0011, I_ADDI);
    add(I_SW,   4'd1, 4'b1000, I_ADDI);
    add(I_SW,   4'd2, 4'b0000, I_ADDI);
    add(I_SW,   4'd3, 4'b0000, I_SW);
    add(I_SW,   4'd4, 4'b0000, I_SW);
    add(I_SW,   4'd5, 4'b0100, I_SW);
    add(I_SW,   4'd6, 4'b0000, I_SW);
    add(I_SW,   4'd7, 4'b0001, I_SW);
    add(I_BEQ,  4'd1, 4'b1000, I_SW);
    add(I_BEQ,  4'd2, 4'b0000, I_SW);
    add(I_BEQ,  4'd3, 4'b0000, I_BEQ);
    add(I_BEQ,  4'd4, 4'b0000, I_BEQ);
    add(I_BEQ,  4'd7, 4'b0001, I_BEQ);
    add(I_NOP,  4'd1, 4'b1000, I_BEQ);
    add(I_NOP,  4'd2, 4'b0000, I_BEQ);
    add(I_NOP,  4'd3, 4'b0000, I_NOP);
    add(I_NOP,  4'd4, 4'b0000, I_NOP);
    add(I_NOP,  4'd7, 4'b0001, I_NOP);
    add(I_NOP,  4'd1, 4'b1000, I_NOP);

    step();
    rst = 1'b0;
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
    lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
    foreach (vecs[i]) begin
      ifu_rsp_data = vecs[i].data;
      check($sformatf("vec%0d.state", i),   32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d.strobes", i), 32'(strobes()), 32'(vecs[i].exp_strb));
      check($sformatf("vec%0d.inst", i),    inst, vecs[i].exp_inst);
      step();
    end

    // lw: data memory accepts on the 4th MEM cycle, responds in the 2nd WAIT_D cycle.
    do_reset();
    ifu_rsp_data = I_LW;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    step();
    check("lw.start_fetch", 32'(state), 32'd1);
    cycles = 0; mem_n = 0; wd_n = 0; lv_n = 0; rf_n = 0; pc_n = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      cycles++;
      if (lsu_req_valid) lv_n++;
      if (state == 4'd5) begin mem_n++; lsu_req_ready = (mem_n == 4); end
      else lsu_req_ready = 1'b0;
      if (state == 4'd6) begin wd_n++; lsu_rsp_valid = (wd_n == 2); end
      else lsu_rsp_valid = 1'b0;
      if (state == 4'd7) begin rf_n += int'(rf_we); pc_n += int'(pc_we); end
      step();
      if (state == 4'd1) done = 1;
    end
    check("lw.returned",       32'(done), 32'd1);
    check("lw.cycles",         cycles, 11);
    check("lw.lsu_req_cycles", lv_n, 4);
    check("lw.wait_d_cycles",  wd_n, 2);
    check("lw.rf_we",          rf_n, 1);
    check("lw.pc_we",          pc_n, 1);

    // ebreak halts; then an asynchronous reset mid-cycle clears it at once.
    do_reset();
    ifu_rsp_data = I_EBREAK;
    lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (state == 4'd8) done = 1;
    end
    check("ebreak.state",  32'(state), 32'd8);
    check("ebreak.halted", 32'(halted), 32'd1);
    check("ebreak.err",    32'(err), 32'd0);
    strb_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (strobes() != 4'b0000) strb_n++;
      step();
    end
    check("ebreak.no_strobes", strb_n, 0);
    check("ebreak.still_halt", 32'({state, halted}), 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.state",  32'(state), 32'd0);
    check("async_rst.halted", 32'(halted), 32'd0);
    check("async_rst.inst",   inst, I_NOP);
    step();
    rst = 1'b0;

    // Fetch never accepted: ERR on the 256th edge after FETCH entry.
    ifu_req_ready = 1'b0;
    step();
    for (int c = 0; c < 255; c++) step();
    check("to_fetch.last_wait", 32'(state), 32'd1);
    check("to_fetch.no_err",    32'(err), 32'd0);
    step();
    check("to_fetch.state",   32'(state), 32'd9);
    check("to_fetch.err",     32'(err), 32'd1);
    for (int c = 0; c < 5; c++) step();
    check("to_fetch.sticky",  32'({state, err, ifu_req_valid}), 32'h26);

    // Handshake in the very cycle the counter equals TIMEOUT wins.
    do_reset();
    step();
    for (int c = 0; c < 255; c++) step();
    ifu_req_ready = 1'b1;
    step();
    check("to_race.state", 32'(state), 32'd2);
    check("to_race.err",   32'(err), 32'd0);

    // Data-memory request never accepted: same limit applies in MEM.
    ifu_rsp_data = I_SW;
    lsu_req_ready = 1'b0;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (state == 4'd5) done = 1;
    end
    check("to_mem.reached", 32'(state), 32'd5);
    for (int c = 0; c < 255; c++) step();
    check("to_mem.last_wait", 32'({state, lsu_req_valid}), 32'hB);
    step();
    check("to_mem.err", 32'({state, err}), 32'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
